// File: rtl/cp0_exc_if.sv
// CP0 exception controller bus: mtc0/mfc0 access, victim info, interrupt lines and redirect outputs.
interface cp0_exc_if;
  logic        we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        eret;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;
  logic [31:0] cp0_rdata;

  modport master (
    output we, cp0_addr, cp0_wdata, vpc, bd_in, exc_code_in, hw_int, eret,
    input  req, handler_pc, epc_out, cp0_rdata
  );
  modport slave (
    input  we, cp0_addr, cp0_wdata, vpc, bd_in, exc_code_in, hw_int, eret,
    output req, handler_pc, epc_out, cp0_rdata
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller (SR/Cause/EPC/PRId) at the M stage.
// Define CP0_TIMER_EN to add Count(9)/Compare(11) and the timer interrupt on IP[15].
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID    = 32'h2022_1104,
  parameter logic [31:0] HANDLER = 32'h0000_4180
) (
  input logic      clk,
  input logic      reset,
  cp0_exc_if.slave bus
);
  logic [5:0]  im_q, im_d, ip_q, ip_d;
  logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic        int_req, exc_req, req, wr;
  logic [31:0] vpc_al, victim;
  logic        unused_vpc;

  assign unused_vpc = ^bus.vpc[1:0];

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic        pend_q, pend_d;

  assign ip_d = {bus.hw_int[5] | pend_q, bus.hw_int[4:0]};

  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    pend_d    = pend_q | (count_q == compare_q);
    if (wr && bus.cp0_addr == 5'd9) count_d = bus.cp0_wdata;
    // A Compare write acknowledges the timer even on a matching cycle
    if (wr && bus.cp0_addr == 5'd11) begin
      compare_d = bus.cp0_wdata;
      pend_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end
`else
  assign ip_d = bus.hw_int;
`endif

  // Interrupt uses the IP value being latched this cycle, not the stale one
  assign int_req = (|(ip_d & im_q)) & ie_q & ~exl_q;
  assign exc_req = (bus.exc_code_in != 5'd0) & ~exl_q;
  assign req     = ~reset & (int_req | exc_req);
  assign wr      = bus.we & ~req;
  assign vpc_al  = {bus.vpc[31:2], 2'b00};
  assign victim  = bus.bd_in ? vpc_al - 32'd4 : vpc_al;

  always_comb begin
    im_d   = im_q;
    ie_d   = ie_q;
    exl_d  = exl_q;
    bd_d   = bd_q;
    code_d = code_q;
    epc_d  = epc_q;
    if (wr && bus.cp0_addr == 5'd12) begin
      im_d  = bus.cp0_wdata[15:10];
      ie_d  = bus.cp0_wdata[0];
      exl_d = bus.cp0_wdata[1];
    end
    if (wr && bus.cp0_addr == 5'd14) epc_d = {bus.cp0_wdata[31:2], 2'b00};
    if (bus.eret) exl_d = 1'b0;
    if (req) begin
      exl_d  = 1'b1;
      bd_d   = bus.bd_in;
      code_d = int_req ? 5'd0 : bus.exc_code_in;
      epc_d  = victim;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q   <= '0;
      ie_q   <= 1'b0;
      exl_q  <= 1'b0;
      bd_q   <= 1'b0;
      code_q <= '0;
      ip_q   <= '0;
      epc_q  <= '0;
    end else begin
      im_q   <= im_d;
      ie_q   <= ie_d;
      exl_q  <= exl_d;
      bd_q   <= bd_d;
      code_q <= code_d;
      ip_q   <= ip_d;
      epc_q  <= epc_d;
    end
  end

  always_comb begin
    bus.cp0_rdata = '0;
    unique case (bus.cp0_addr)
      5'd12:   bus.cp0_rdata = {16'b0, im_q, 8'b0, exl_q, ie_q};
      5'd13:   bus.cp0_rdata = {bd_q, 15'b0, ip_q, 3'b0, code_q, 2'b0};
      5'd14:   bus.cp0_rdata = epc_q;
      5'd15:   bus.cp0_rdata = PRID;
`ifdef CP0_TIMER_EN
      5'd9:    bus.cp0_rdata = count_q;
      5'd11:   bus.cp0_rdata = compare_q;
`endif
      default: bus.cp0_rdata = '0;
    endcase
  end

  assign bus.req        = req;
  assign bus.handler_pc = HANDLER;
  assign bus.epc_out    = (bus.we && bus.cp0_addr == 5'd14 && !req) ?
                          {bus.cp0_wdata[31:2], 2'b00} : epc_q;
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed self-checking bench for cp0_exc_ctrl; hand-computed expected values.
module tb_cp0_exc_ctrl;
  logic clk, reset;
  int   n_chk, n_err;

  cp0_exc_if bus ();
  cp0_exc_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.cp0_addr = 5'd0; bus.cp0_wdata = '0;
    bus.vpc = '0; bus.bd_in = 1'b0; bus.exc_code_in = 5'd0; bus.eret = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.cp0_addr = a; bus.cp0_wdata = d;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic mfc0(input string tag, input logic [4:0] a, input logic [31:0] exp);
    bus.cp0_addr = a;
    #1;
    check(tag, bus.cp0_rdata, exp);
  endtask

  task automatic do_eret();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    idle();
    bus.hw_int = '0;
    reset = 1'b1;
    bus.exc_code_in = 5'd12;
    repeat (3) tick();
    check("req_in_reset", {31'b0, bus.req}, 32'd0);
    check("handler_pc", bus.handler_pc, 32'h0000_4180);
    check("epc_out_rst", bus.epc_out, 32'd0);
    bus.exc_code_in = 5'd0;
    mfc0("sr_rst", 5'd12, 32'd0);
    mfc0("cause_rst", 5'd13, 32'd0);
    mfc0("epc_rst", 5'd14, 32'd0);
    reset = 1'b0;
`ifdef CP0_TIMER_EN
    mtc0(5'd11, 32'hFFFF_0000);
`endif

    // 1: Ov exception entry
    bus.exc_code_in = 5'd12; bus.vpc = 32'h3004;
    #1 check("t1_req", {31'b0, bus.req}, 32'd1);
    tick(); idle();
    mfc0("t1_sr", 5'd12, 32'h0000_0002);
    mfc0("t1_cause", 5'd13, 32'h0000_0030);
    mfc0("t1_epc", 5'd14, 32'h0000_3004);
    do_eret();
    mfc0("t1_sr_eret", 5'd12, 32'd0);

    // 2: interrupt via IM[10]/IE, then masked by IE=0
    mtc0(5'd12, 32'h0000_0401);
    mfc0("t2_sr", 5'd12, 32'h0000_0401);
    bus.hw_int = 6'b000001;
    #1 check("t2_req", {31'b0, bus.req}, 32'd1);
    tick();
    mfc0("t2_cause", 5'd13, 32'h0000_0400);
    bus.hw_int = '0;
    do_eret();
    mtc0(5'd12, 32'h0000_0400);
    bus.hw_int = 6'b000001;
    #1 check("t2_req_ie0", {31'b0, bus.req}, 32'd0);
    bus.hw_int = '0;

    // 3: AdEL in delay slot, nested exception dropped
    bus.exc_code_in = 5'd4; bus.bd_in = 1'b1; bus.vpc = 32'h3010;
    tick(); idle();
    mfc0("t3_epc", 5'd14, 32'h0000_300C);
    mfc0("t3_cause", 5'd13, 32'h8000_0010);
    bus.exc_code_in = 5'd10;
    #1 check("t3_nested_req", {31'b0, bus.req}, 32'd0);
    tick(); idle();
    mfc0("t3_cause_kept", 5'd13, 32'h8000_0010);

    // 4: EPC forwarding and eret
    bus.we = 1'b1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'h3021;
    #1 check("t4_fwd", bus.epc_out, 32'h0000_3020);
    tick(); idle();
    bus.eret = 1'b1;
    #1 check("t4_eret_epc", bus.epc_out, 32'h0000_3020);
    tick(); idle();
    mfc0("t4_sr", 5'd12, 32'h0000_0400);
    bus.exc_code_in = 5'd12; bus.vpc = 32'h5008;
    bus.we = 1'b1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'h7777_0000;
    #1 check("t4_nofwd_req", bus.epc_out, 32'h0000_3020);
    tick(); idle();
    mfc0("t4_epc_victim", 5'd14, 32'h0000_5008);
    do_eret();
    bus.exc_code_in = 5'd5; bus.vpc = 32'h0; bus.bd_in = 1'b1;
    tick(); idle();
    mfc0("epc_wrap", 5'd14, 32'hFFFF_FFFC);
    mfc0("wrap_cause", 5'd13, 32'h8000_0014);
    do_eret();

    // 5: interrupt beats exception; read-only / unimplemented regs
    mtc0(5'd12, 32'h0000_0401);
    bus.hw_int = 6'b000001; bus.exc_code_in = 5'd12; bus.vpc = 32'h6000;
    #1 check("t5_req", {31'b0, bus.req}, 32'd1);
    tick(); idle();
    bus.hw_int = '0;
    mfc0("t5_cause", 5'd13, 32'h0000_0400);
    mfc0("t5_epc", 5'd14, 32'h0000_6000);
    do_eret();
    mfc0("t5_prid", 5'd15, 32'h2022_1104);
    mfc0("t5_addr3", 5'd3, 32'd0);
    mtc0(5'd13, 32'hFFFF_FFFF);
    mfc0("cause_ro", 5'd13, 32'd0);
    mtc0(5'd15, 32'd0);
    mfc0("prid_ro", 5'd15, 32'h2022_1104);
    bus.exc_code_in = 5'd4;
    tick(); idle();
    bus.eret = 1'b1;
    mtc0(5'd12, 32'h0000_0403);
    bus.eret = 1'b0;
    mfc0("eret_wins", 5'd12, 32'h0000_0401);

`ifdef CP0_TIMER_EN
    // 6: timer interrupt once Count reaches Compare
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h0000_8001);
    begin
      bit seen = 1'b0;
      bus.cp0_addr = 5'd9;
      for (int i = 0; i < 20 && !seen; i++) begin
        #1;
        if (bus.req) seen = 1'b1;
        else tick();
      end
      check("t6_timer_req", {31'b0, seen}, 32'd1);
      check("t6_count", bus.cp0_rdata, 32'd6);
    end
    tick();
    mfc0("t6_cause", 5'd13, 32'h0000_8000);
    mtc0(5'd11, 32'd100);
    tick();
    mfc0("t6_pend_clr", 5'd13, 32'd0);
`else
    mtc0(5'd9, 32'h1234);
    mfc0("no_count", 5'd9, 32'd0);
    mtc0(5'd11, 32'h5678);
    mfc0("no_compare", 5'd11, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
